// File: rtl/mult_arbiter_pkg.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// Module   : mult_arbiter_pkg
// Brief    : Shared types and widths for the two-requester multiplier arbiter.
// Revision : 1.0
//////////////////////////////////////////////////////////////////////////////
package mult_arbiter_pkg;

  localparam int c_op_w       = 4;
  localparam int c_prod_w     = 8;
  localparam int c_settle_max = 15;
  localparam int c_cnt_w      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mult.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// Module   : mult
// Brief    : Combinational unsigned 4x4 array multiplier (shift-and-add).
// Revision : 1.0
//////////////////////////////////////////////////////////////////////////////
module mult
  import mult_arbiter_pkg::*;
(
  input  logic [c_op_w-1:0]   a,
  input  logic [c_op_w-1:0]   b,
  output logic [c_prod_w-1:0] p
);

  logic [c_prod_w-1:0] w_pp [c_op_w];

  for (genvar i = 0; i < c_op_w; i++) begin : g_pp
    assign w_pp[i] = b[i] ? (c_prod_w'(a) << i) : '0;
  end

  always_comb begin
    p = '0;
    for (int i = 0; i < c_op_w; i++) begin
      p = p + w_pp[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// Module   : mult_arbiter
// Brief    : Shares one multicycle 4x4 multiplier between two valid/ready
//            requesters. Define MULT_ARB_RR_EN for round-robin tie breaking;
//            otherwise requester 0 has fixed priority.
// Revision : 1.0
//////////////////////////////////////////////////////////////////////////////
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [c_op_w-1:0]   req0_a,
  input  logic [c_op_w-1:0]   req0_b,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [c_prod_w-1:0] rsp0_p,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [c_op_w-1:0]   req1_a,
  input  logic [c_op_w-1:0]   req1_b,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [c_prod_w-1:0] rsp1_p,
  output logic                busy
);

  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(SETTLE_CYC - 1);
`ifdef MULT_ARB_RR_EN
  localparam logic c_rr_en = 1'b1;
`else
  localparam logic c_rr_en = 1'b0;
`endif

  state_t              r_state;
  logic                r_last_gnt;
  logic                r_owner;
  logic                r_rsp0_valid;
  logic                r_rsp1_valid;
  logic                r_busy;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_op_w-1:0]   r_op_a;
  logic [c_op_w-1:0]   r_op_b;
  logic [c_prod_w-1:0] r_res;
  logic [c_prod_w-1:0] w_p;
  logic                w_pick1;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_rsp_take;

  // Requester 1 wins alone, or on a tie when round-robin says it is its turn.
  assign w_pick1    = req1_valid & (~req0_valid | (c_rr_en & ~r_last_gnt));
  assign w_gnt1     = (r_state == ST_IDLE) & w_pick1;
  assign w_gnt0     = (r_state == ST_IDLE) & req0_valid & ~w_pick1;
  assign w_rsp_take = r_owner ? rsp1_ready : rsp0_ready;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_p     = r_res;
  assign rsp1_p     = r_res;
  assign busy       = r_busy;

  mult u_mult (
    .a (r_op_a),
    .b (r_op_b),
    .p (w_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_gnt   <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_res        <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_op_a  <= w_gnt1 ? req1_a : req0_a;
            r_op_b  <= w_gnt1 ? req1_b : req0_b;
            r_owner <= w_gnt1;
            r_cnt   <= c_cnt_load;
            r_busy  <= 1'b1;
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // Operands have been stable on the array for SETTLE_CYC cycles here.
          if (r_cnt == '0) begin
            r_res        <= w_p;
            r_rsp0_valid <= ~r_owner;
            r_rsp1_valid <= r_owner;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (w_rsp_take) begin
            r_last_gnt   <= r_owner;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_rsp0_valid <= 1'b0;
          r_rsp1_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// Module   : tb_mult_arbiter
// Brief    : Self-checking bench: transaction-level model plus directed cases.
// Revision : 1.0
//////////////////////////////////////////////////////////////////////////////
module tb_mult_arbiter;

  localparam int SC = 2;
`ifdef MULT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [7:0] rsp0_p, rsp1_p;
  logic       busy;

  logic [1:0]      xv = '0;
  logic [1:0][3:0] xa = '0, xb = '0;
  logic [1:0]      xr, xrv, xr1, xrv1, xbusy;
  logic [1:0][7:0] xp, xp1;

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  int gnt_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_arbiter #(.SETTLE_CYC(SC)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p),
    .busy(busy)
  );

  for (genvar g = 0; g < 2; g++) begin : g_lat
    mult_arbiter #(.SETTLE_CYC(g == 0 ? 1 : 15)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(xv[g]), .req0_ready(xr[g]), .req0_a(xa[g]), .req0_b(xb[g]),
      .rsp0_valid(xrv[g]), .rsp0_ready(1'b1), .rsp0_p(xp[g]),
      .req1_valid(1'b0), .req1_ready(xr1[g]), .req1_a(4'd0), .req1_b(4'd0),
      .rsp1_valid(xrv1[g]), .rsp1_ready(1'b1), .rsp1_p(xp1[g]),
      .busy(xbusy[g])
    );
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Transaction-level model: one outstanding job with a due cycle for its result.
  int m_n = 0, m_valid_at = 0, m_prod = 0;
  bit m_idle = 1'b1, m_owner = 1'b0, m_last = 1'b1;
  always @(negedge clk) begin : p_model
    bit e_r0, e_r1, e_v0, e_v1;
    m_n++;
    if (!rst_n) begin
      m_idle = 1'b1;
      m_last = 1'b1;
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp0_p", rsp0_p, 0);
      chk("rst_rsp1_p", rsp1_p, 0);
    end else begin
      e_r1 = m_idle && req1_valid && (!req0_valid || (RR && !m_last));
      e_r0 = m_idle && req0_valid && !e_r1;
      e_v0 = !m_idle && (m_n >= m_valid_at) && !m_owner;
      e_v1 = !m_idle && (m_n >= m_valid_at) && m_owner;
      chk("req0_ready", req0_ready, int'(e_r0));
      chk("req1_ready", req1_ready, int'(e_r1));
      chk("rsp0_valid", rsp0_valid, int'(e_v0));
      chk("rsp1_valid", rsp1_valid, int'(e_v1));
      chk("busy", busy, int'(!m_idle));
      if (e_v0) chk("rsp0_p", rsp0_p, m_prod);
      if (e_v1) chk("rsp1_p", rsp1_p, m_prod);
      if (e_r0 || e_r1) begin
        m_idle = 1'b0;
        m_owner = e_r1;
        m_prod = e_r1 ? int'(req1_a) * int'(req1_b) : int'(req0_a) * int'(req0_b);
        m_valid_at = m_n + SC + 1;
      end else if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) begin
        m_idle = 1'b1;
        m_last = m_owner;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && req0_valid && req0_ready) gnt_log.push_back(0);
    if (rst_n && req1_valid && req1_ready) gnt_log.push_back(1);
  end

  task automatic set_req(input int r, input bit v, input logic [3:0] a, input logic [3:0] b);
    if (r == 0) begin req0_valid = v; req0_a = a; req0_b = b; end
    else        begin req1_valid = v; req1_a = a; req1_b = b; end
  endtask

  function automatic bit rdy(input int r);
    return (r == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic bit rv(input int r);
    return (r == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  function automatic int rp(input int r);
    return (r == 0) ? int'(rsp0_p) : int'(rsp1_p);
  endfunction

  task automatic issue(input int r, input logic [3:0] a, input logic [3:0] b, output int acc);
    @(posedge clk); #1;
    set_req(r, 1'b1, a, b);
    acc = -1;
    for (int i = 0; i < 40 && acc < 0; i++) begin
      @(negedge clk);
      if (rdy(r)) acc = cyc;
    end
    @(posedge clk); #1;
    set_req(r, 1'b0, a, b);
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic single(input int r, input logic [3:0] a, input logic [3:0] b, input int exp_p);
    int acc, got;
    issue(r, a, b, acc);
    got = -1;
    for (int i = 0; i < 40 && got < 0; i++) begin
      @(negedge clk);
      if (rv(r)) got = cyc;
    end
    chk("single_latency", got - acc, 3);
    chk("single_p", rp(r), exp_p);
    wait_idle();
  endtask

  task automatic lat_x(input int g, input logic [3:0] a, input logic [3:0] b,
                       input int exp_lat, input int exp_p);
    int acc, got;
    @(posedge clk); #1;
    xa[g] = a; xb[g] = b; xv[g] = 1'b1;
    acc = -1;
    for (int i = 0; i < 40 && acc < 0; i++) begin
      @(negedge clk);
      if (xr[g]) acc = cyc;
    end
    @(posedge clk); #1;
    xv[g] = 1'b0;
    got = -1;
    for (int i = 0; i < 40 && got < 0; i++) begin
      @(negedge clk);
      if (xrv[g]) got = cyc;
    end
    chk("x_latency", got - acc, exp_lat);
    chk("x_rsp0_p", xp[g], exp_p);
    chk("x_rsp1_p_res", xp1[g], exp_p);
    chk("x_rsp1_valid", xrv1[g], 0);
    chk("x_req1_ready", xr1[g], 0);
    chk("x_busy", xbusy[g], 1);
  endtask

  initial begin : p_stim
    int acc;
    int exp_seq[4];
    bit a0, a1;

    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    single(0, 4'd7, 4'd9, 63);
    single(1, 4'd15, 4'd15, 225);
    single(0, 4'd0, 4'd13, 0);
    single(1, 4'd1, 4'd11, 11);

    // Tie: both requesters hold valid continuously.
    @(posedge clk); #1;
    gnt_log.delete();
    set_req(0, 1'b1, 4'd2, 4'd2);
    set_req(1, 1'b1, 4'd3, 4'd3);
    for (int i = 0; i < 80 && gnt_log.size() < 4; i++) @(negedge clk);
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'd0, 4'd0);
    set_req(1, 1'b0, 4'd0, 4'd0);
    chk("tie_grants", gnt_log.size(), 4);
    if (RR) exp_seq = '{0, 1, 0, 1};
    else    exp_seq = '{0, 0, 0, 0};
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("tie_winner", gnt_log[i], exp_seq[i]);
    wait_idle();

    // Back-pressure on requester 1 while requester 0 waits.
    rsp1_ready = 1'b0;
    issue(1, 4'd12, 4'd13, acc);
    for (int i = 0; i < 20 && !rsp1_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    set_req(0, 1'b1, 4'd2, 4'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp1_valid", rsp1_valid, 1);
      chk("bp_rsp1_p", rsp1_p, 156);
      chk("bp_busy", busy, 1);
      chk("bp_req0_ready", req0_ready, 0);
    end
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_busy", busy, 0);
    chk("bp_release_req0_ready", req0_ready, 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'd0, 4'd0);
    wait_idle();

    // Reset during SETTLE discards the job.
    issue(0, 4'd5, 4'd5, acc);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp0_valid", rsp0_valid, 0);
    chk("midrst_rsp0_p", rsp0_p, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", rsp0_valid, 0);
    end
    single(0, 4'd3, 4'd4, 12);

    // Randomized traffic; requesters hold valid and operands until accepted.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(0, 2) == 0) set_req(0, 1'b1, 4'($urandom), 4'($urandom));
      if (!req1_valid && $urandom_range(0, 2) == 0) set_req(1, 1'b1, 4'($urandom), 4'($urandom));
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int c = 0; c < 100 && (req0_valid || req1_valid); c++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end
    chk("drain_req0", req0_valid, 0);
    chk("drain_req1", req1_valid, 0);
    wait_idle();

    lat_x(0, 4'd6, 4'd7, 2, 42);
    lat_x(1, 4'd15, 4'd15, 16, 225);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : p_watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
